countup_stopwatch: RTL and testbench

- Count-up BCD stopwatch (HH:MM:SS); the up-counting counterpart of the team's countdown timer.
- Shares the timer's 1 Hz tick, start/stop key and 3×8-bit BCD display bus, so the display mux can select either block.
- Start/pause/resume is controlled by one key (CS).
- Wrap from 23:59:59 to 00:00:00 raises a one-cycle TC pulse.
- Fully synchronous to CP, with one asynchronous active-low reset.

---
 rtl/countup_pkg.sv | 19 +
 rtl/bcd2_up.sv | 54 +++++
 rtl/countup_stopwatch.sv | 168 ++++++++++++++++
 tb/tb_countup_stopwatch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/countup_pkg.sv
// Shared definitions for the count-up stopwatch: state encoding, BCD limits
// and a BCD field validity check used on preset loads.
package countup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [7:0] MOD_60 = 8'h59;
  localparam logic [7:0] MOD_24 = 8'h23;

  // A field is usable only if both nibbles are decimal digits and it does not exceed its limit.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/bcd2_up.sv
// Two-digit synchronous BCD up-counter; wraps to 00 after max and flags the
// wrap combinationally on carry so counters can be chained enable-to-carry.
module bcd2_up
  import countup_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] d,
  input  logic [7:0] max,
  output logic [7:0] q,
  output logic       carry
);

  logic [7:0] q_reg;
  logic [7:0] q_next;
  logic [7:0] q_inc;

  always_comb begin
    q_inc = q_reg;
    if (q_reg == max) begin
      q_inc = 8'h00;
    end else if (q_reg[3:0] == 4'd9) begin
      q_inc = {q_reg[7:4] + 4'd1, 4'h0};
    end else begin
      q_inc = q_reg + 8'd1;
    end
  end

  always_comb begin
    q_next = q_reg;
    if (clr) begin
      q_next = 8'h00;
    end else if (load) begin
      q_next = d;
    end else if (en) begin
      q_next = q_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= 8'h00;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q     = q_reg;
  assign carry = en & (q_reg == max);

endmodule

// File: rtl/countup_stopwatch.sv
// Count-up BCD stopwatch HH:MM:SS with single-key start/pause/resume.
// Optional lap hold of the display is enabled by COUNTUP_STOPWATCH_LAP_EN.
module countup_stopwatch
  import countup_pkg::*;
#(
  parameter logic [7:0] MOD_S = MOD_60,
  parameter logic [7:0] MOD_M = MOD_60,
  parameter logic [7:0] MOD_H = MOD_24
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       CE,
  input  logic       CS,
  input  logic       CLR,
  input  logic       PE,
  input  logic [7:0] D_H,
  input  logic [7:0] D_M,
  input  logic [7:0] D_S,
  output logic [7:0] Q_H,
  output logic [7:0] Q_M,
  output logic [7:0] Q_S,
  output logic       RUN,
  output logic       TC
`ifdef COUNTUP_STOPWATCH_LAP_EN
  ,
  input  logic       LAP,
  output logic       HOLD
`endif
);

  state_t     state_reg;
  state_t     state_next;
  logic       cs_q_reg;
  logic       cs_rise;
  logic       tick_en;
  logic       tc_reg;
  logic [7:0] load_s;
  logic [7:0] load_m;
  logic [7:0] load_h;
  logic [7:0] cnt_s;
  logic [7:0] cnt_m;
  logic [7:0] cnt_h;
  logic       carry_s;
  logic       carry_m;
  logic       carry_h;

  assign cs_rise = CS & ~cs_q_reg;

  // CLR/PE discard a same-cycle tick; the tick is judged on the registered state only.
  assign tick_en = (state_reg == ST_RUN) & CE & ~CLR & ~PE;

  assign load_s = bcd_valid(D_S, MOD_S) ? D_S : 8'h00;
  assign load_m = bcd_valid(D_M, MOD_M) ? D_M : 8'h00;
  assign load_h = bcd_valid(D_H, MOD_H) ? D_H : 8'h00;

  always_comb begin
    state_next = state_reg;
    if (CLR) begin
      state_next = ST_IDLE;
    end else if (PE) begin
      state_next = ST_PAUSE;
    end else if (cs_rise) begin
      case (state_reg)
        ST_IDLE:  state_next = ST_RUN;
        ST_RUN:   state_next = ST_PAUSE;
        ST_PAUSE: state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_reg <= ST_IDLE;
      cs_q_reg  <= 1'b0;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cs_q_reg  <= CS;
      tc_reg    <= carry_h;
    end
  end

  bcd2_up u_sec (
    .clk   (CP),
    .rst_n (CR),
    .en    (tick_en),
    .clr   (CLR),
    .load  (PE),
    .d     (load_s),
    .max   (MOD_S),
    .q     (cnt_s),
    .carry (carry_s)
  );

  bcd2_up u_min (
    .clk   (CP),
    .rst_n (CR),
    .en    (carry_s),
    .clr   (CLR),
    .load  (PE),
    .d     (load_m),
    .max   (MOD_M),
    .q     (cnt_m),
    .carry (carry_m)
  );

  bcd2_up u_hour (
    .clk   (CP),
    .rst_n (CR),
    .en    (carry_m),
    .clr   (CLR),
    .load  (PE),
    .d     (load_h),
    .max   (MOD_H),
    .q     (cnt_h),
    .carry (carry_h)
  );

  assign RUN = (state_reg == ST_RUN);
  assign TC  = tc_reg;

`ifdef COUNTUP_STOPWATCH_LAP_EN
  logic       lap_q_reg;
  logic       lap_rise;
  logic       hold_reg;
  logic [7:0] snap_s_reg;
  logic [7:0] snap_m_reg;
  logic [7:0] snap_h_reg;

  assign lap_rise = LAP & ~lap_q_reg;

  // Snapshot is the value on display at the LAP edge; the live count keeps going.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      lap_q_reg  <= 1'b0;
      hold_reg   <= 1'b0;
      snap_s_reg <= 8'h00;
      snap_m_reg <= 8'h00;
      snap_h_reg <= 8'h00;
    end else begin
      lap_q_reg <= LAP;
      if (CLR || PE || cs_rise) begin
        hold_reg <= 1'b0;
      end else if (lap_rise) begin
        if (hold_reg) begin
          hold_reg <= 1'b0;
        end else if (state_reg == ST_RUN) begin
          hold_reg   <= 1'b1;
          snap_s_reg <= cnt_s;
          snap_m_reg <= cnt_m;
          snap_h_reg <= cnt_h;
        end
      end
    end
  end

  assign HOLD = hold_reg;
  assign Q_S  = hold_reg ? snap_s_reg : cnt_s;
  assign Q_M  = hold_reg ? snap_m_reg : cnt_m;
  assign Q_H  = hold_reg ? snap_h_reg : cnt_h;
`else
  assign Q_S = cnt_s;
  assign Q_M = cnt_m;
  assign Q_H = cnt_h;
`endif

endmodule

// File: tb/tb_countup_stopwatch.sv
// Directed bench for countup_stopwatch; inputs change and outputs are sampled on CP falling edges.
module tb_countup_stopwatch;

  logic       cp;
  logic       cr;
  logic       ce;
  logic       cs;
  logic       clr;
  logic       pe;
  logic [7:0] d_h;
  logic [7:0] d_m;
  logic [7:0] d_s;
  logic [7:0] q_h;
  logic [7:0] q_m;
  logic [7:0] q_s;
  logic       run;
  logic       tc;
`ifdef COUNTUP_STOPWATCH_LAP_EN
  logic       lap;
  logic       hold;
`endif

  int errors = 0;
  int checks = 0;

  countup_stopwatch dut (
    .CP   (cp),
    .CR   (cr),
    .CE   (ce),
    .CS   (cs),
    .CLR  (clr),
    .PE   (pe),
    .D_H  (d_h),
    .D_M  (d_m),
    .D_S  (d_s),
    .Q_H  (q_h),
    .Q_M  (q_m),
    .Q_S  (q_s),
    .RUN  (run),
    .TC   (tc)
`ifdef COUNTUP_STOPWATCH_LAP_EN
    ,
    .LAP  (lap),
    .HOLD (hold)
`endif
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [31:0] time_q();
    return {8'h00, q_h, q_m, q_s};
  endfunction

  // CE held high for n consecutive edges.
  task automatic tick(input int n);
    ce = 1'b1;
    repeat (n) @(posedge cp);
    @(negedge cp);
    ce = 1'b0;
  endtask

  task automatic cs_pulse();
    cs = 1'b1;
    @(negedge cp);
    cs = 1'b0;
    @(negedge cp);
  endtask

  task automatic preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    d_h = h;
    d_m = m;
    d_s = s;
    pe  = 1'b1;
    @(negedge cp);
    pe  = 1'b0;
  endtask

  initial begin
    cr = 1'b1; ce = 1'b0; cs = 1'b0; clr = 1'b0; pe = 1'b0;
    d_h = 8'h00; d_m = 8'h00; d_s = 8'h00;
`ifdef COUNTUP_STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    #2 cr = 1'b0;
    #1;
    chk("reset_q", time_q(), 32'h000000);
    chk("reset_run", {31'd0, run}, 32'd0);
    chk("reset_tc", {31'd0, tc}, 32'd0);
    repeat (2) @(negedge cp);
    cr = 1'b1;
    @(negedge cp);

    // First start and three ticks (CE held high across them)
    cs_pulse();
    chk("start_run", {31'd0, run}, 32'd1);
    tick(3);
    chk("start_q", time_q(), 32'h000003);

    // Pause / resume
    tick(2);
    chk("pre_pause_q", time_q(), 32'h000005);
    cs_pulse();
    chk("pause_run", {31'd0, run}, 32'd0);
    tick(4);
    chk("pause_q", time_q(), 32'h000005);
    cs_pulse();
    chk("resume_run", {31'd0, run}, 32'd1);
    tick(2);
    chk("resume_q", time_q(), 32'h000007);

    // Full wrap 23:59:59 -> 00:00:00
    preset(8'h23, 8'h59, 8'h58);
    chk("preset_q", time_q(), 32'h235958);
    chk("preset_run", {31'd0, run}, 32'd0);
    cs_pulse();
    tick(1);
    chk("wrap_q1", time_q(), 32'h235959);
    chk("wrap_tc0", {31'd0, tc}, 32'd0);
    tick(1);
    chk("wrap_q2", time_q(), 32'h000000);
    chk("wrap_tc1", {31'd0, tc}, 32'd1);
    @(negedge cp);
    chk("wrap_tc_drop", {31'd0, tc}, 32'd0);

    // Minute-to-hour carry without TC
    preset(8'h00, 8'h59, 8'h59);
    cs_pulse();
    tick(1);
    chk("hour_carry_q", time_q(), 32'h010000);
    chk("hour_carry_tc", {31'd0, tc}, 32'd0);

    // Seconds low-nibble carry
    preset(8'h00, 8'h00, 8'h09);
    cs_pulse();
    tick(1);
    chk("nibble_carry_q", time_q(), 32'h000010);

    // Invalid preset fields load 00
    preset(8'h24, 8'h5A, 8'h30);
    chk("invalid_q", time_q(), 32'h000030);
    chk("invalid_run", {31'd0, run}, 32'd0);
    tick(2);
    chk("invalid_paused", time_q(), 32'h000030);

    // CLR, PE and CE together in RUN
    cs_pulse();
    chk("combo_pre_run", {31'd0, run}, 32'd1);
    d_h = 8'h11; d_m = 8'h22; d_s = 8'h33;
    clr = 1'b1; pe = 1'b1; ce = 1'b1;
    @(negedge cp);
    clr = 1'b0; pe = 1'b0; ce = 1'b0;
    chk("combo_q", time_q(), 32'h000000);
    chk("combo_run", {31'd0, run}, 32'd0);
    // IDLE resumes counting on the next start from 00:00:00
    cs_pulse();
    tick(1);
    chk("idle_restart_q", time_q(), 32'h000001);

    // cs_rise and CE together in RUN
    preset(8'h00, 8'h00, 8'h10);
    cs_pulse();
    cs = 1'b1; ce = 1'b1;
    @(negedge cp);
    cs = 1'b0; ce = 1'b0;
    chk("cs_ce_q", time_q(), 32'h000011);
    chk("cs_ce_run", {31'd0, run}, 32'd0);
    tick(1);
    chk("cs_ce_paused", time_q(), 32'h000011);

    // Async reset mid-run at 12:34:56
    preset(8'h12, 8'h34, 8'h56);
    cs_pulse();
    chk("mid_run", {31'd0, run}, 32'd1);
`ifdef COUNTUP_STOPWATCH_LAP_EN
    lap = 1'b1;
    @(negedge cp);
    lap = 1'b0;
    chk("lap_hold", {31'd0, hold}, 32'd1);
    tick(2);
    chk("lap_frozen_q", time_q(), 32'h123456);
`endif
    #2 cr = 1'b0;
    #1;
    chk("async_q", time_q(), 32'h000000);
    chk("async_run", {31'd0, run}, 32'd0);
`ifdef COUNTUP_STOPWATCH_LAP_EN
    chk("async_hold", {31'd0, hold}, 32'd0);
`endif
    @(negedge cp);
    cr = 1'b1;
    @(negedge cp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
